// File: rtl/mem_controller.sv
// Byte-serial memory controller arbitrating LSU and iCache requests onto a byte-wide RAM/IO bus.
// Optional feature: define MEMCON_IO_STALL_EN to hold off IO-region stores while io_buffer_full is high.
module mem_controller (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob2memCon_clear,
    input  logic        iCache2memCon_enable,
    input  logic [31:0] iCache2memCon_addr,
    output logic        memCon2iCache_enable,
    output logic [31:0] memCon2iCache_return,
    input  logic        lsu2memCon_enable,
    input  logic        lsu2memCon_rw,
    input  logic [1:0]  lsu2memCon_width,
    input  logic [31:0] lsu2memCon_addr,
    input  logic [31:0] lsu2memCon_value,
    input  logic        lsu2memCon_ifSigned,
    output logic        memCon2lsu_enable,
    output logic [31:0] memCon2lsu_return,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state;
    logic [2:0]  k;
    logic [2:0]  n;
    logic [31:0] addr;
    logic [31:0] value;
    logic        is_signed;
    logic        from_lsu;
    logic [23:0] rbuf;

    logic        lsu_req;
    logic        accept_ok;
    logic        grant_lsu;
    logic        grant_ic;
    logic [31:0] req_addr;
    logic [31:0] req_value;
    logic        req_rw;
    logic        req_signed;
    logic [2:0]  req_n;
    logic [31:0] raw_word;
    logic [31:0] load_word;

    always_comb begin
        lsu_req = lsu2memCon_enable;
`ifdef MEMCON_IO_STALL_EN
        // Stores to the IO region wait until the IO write buffer has room.
        if (lsu2memCon_rw && lsu2memCon_addr[17:16] == 2'b11 && io_buffer_full)
            lsu_req = 1'b0;
`endif
    end

`ifndef MEMCON_IO_STALL_EN
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        accept_ok  = (state == IDLE) && rdy_in && !rob2memCon_clear;
        grant_lsu  = accept_ok && lsu_req;
        grant_ic   = accept_ok && !lsu_req && iCache2memCon_enable;
        req_addr   = iCache2memCon_addr;
        req_value  = 32'h0;
        req_rw     = 1'b0;
        req_signed = 1'b0;
        req_n      = 3'd4;
        if (grant_lsu) begin
            req_addr   = lsu2memCon_addr;
            req_value  = lsu2memCon_value;
            req_rw     = lsu2memCon_rw;
            req_signed = lsu2memCon_ifSigned;
            case (lsu2memCon_width)
                2'd0:    req_n = 3'd1;
                2'd1:    req_n = 3'd2;
                default: req_n = 3'd4;
            endcase
        end
    end

    // The final byte comes straight off mem_din and joins the buffered lower bytes.
    always_comb begin
        case (n)
            3'd1:    raw_word = {24'h0, mem_din};
            3'd2:    raw_word = {16'h0, mem_din, rbuf[7:0]};
            default: raw_word = {mem_din, rbuf};
        endcase
        load_word = raw_word;
        if (n == 3'd1 && is_signed) load_word[31:8]  = {24{raw_word[7]}};
        if (n == 3'd2 && is_signed) load_word[31:16] = {16{raw_word[15]}};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                <= IDLE;
            k                    <= 3'd0;
            n                    <= 3'd0;
            addr                 <= 32'h0;
            value                <= 32'h0;
            is_signed            <= 1'b0;
            from_lsu             <= 1'b0;
            rbuf                 <= 24'h0;
            mem_a                <= 32'h0;
            mem_dout             <= 8'h0;
            mem_wr               <= 1'b0;
            memCon2lsu_enable    <= 1'b0;
            memCon2lsu_return    <= 32'h0;
            memCon2iCache_enable <= 1'b0;
            memCon2iCache_return <= 32'h0;
        end else begin
            memCon2lsu_enable    <= 1'b0;
            memCon2iCache_enable <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (grant_lsu || grant_ic) begin
                        addr      <= req_addr;
                        value     <= req_value;
                        n         <= req_n;
                        is_signed <= req_signed;
                        from_lsu  <= grant_lsu;
                        mem_a     <= req_addr;
                        mem_dout  <= req_value[7:0];
                        mem_wr    <= req_rw;
                        k         <= 3'd1;
                        state     <= req_rw ? WRITE : READ;
                    end
                end
                READ: begin
                    if (rob2memCon_clear) begin
                        state  <= IDLE;
                        k      <= 3'd0;
                        mem_wr <= 1'b0;
                    end else begin
                        if (k < n) mem_a <= addr + {29'd0, k};
                        // Byte k-2 arrives at edge k; the last byte is consumed at edge n+1.
                        if (k <= n) begin
                            case (k)
                                3'd2:    rbuf[7:0]   <= mem_din;
                                3'd3:    rbuf[15:8]  <= mem_din;
                                3'd4:    rbuf[23:16] <= mem_din;
                                default: ;
                            endcase
                        end
                        if (k == n + 3'd1) begin
                            state <= IDLE;
                            k     <= 3'd0;
                            if (from_lsu) begin
                                memCon2lsu_enable <= 1'b1;
                                memCon2lsu_return <= load_word;
                            end else begin
                                memCon2iCache_enable <= 1'b1;
                                memCon2iCache_return <= load_word;
                            end
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (k < n) begin
                        mem_a    <= addr + {29'd0, k};
                        mem_dout <= value[{k[1:0], 3'b000} +: 8];
                        mem_wr   <= 1'b1;
                        k        <= k + 3'd1;
                    end else begin
                        mem_wr            <= 1'b0;
                        memCon2lsu_enable <= 1'b1;
                        memCon2lsu_return <= 32'h0;
                        state             <= IDLE;
                        k                 <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_controller.md
# mem_controller

Memory controller between the core and the single byte-wide RAM/IO bus. It serves two clients: word instruction fetches from the iCache, and byte/half/word loads and stores from the load-store unit. Each request is serialised into byte transfers, and the block returns one registered result with a one-cycle done pulse. It is the responder side of the `lsu2memCon_*` / `memCon2lsu_*` request protocol.

## Interface
- No parameters.
- `clk_in` input 1: clock.
- `rst_in` input 1: synchronous reset, active-high.
- `rdy_in` input 1: when low, no new request is accepted; a transfer already in progress runs to completion.
- `rob2memCon_clear` input 1: misprediction flush.
- `iCache2memCon_enable` input 1: fetch request, level.
- `iCache2memCon_addr` input 32: fetch byte address.
- `memCon2iCache_enable` output 1: fetch done pulse.
- `memCon2iCache_return` output 32: fetched word.
- `lsu2memCon_enable` input 1: LSU request, level.
- `lsu2memCon_rw` input 1: 0 = read, 1 = write.
- `lsu2memCon_width` input 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `lsu2memCon_addr` input 32: byte address.
- `lsu2memCon_value` input 32: store data, low bytes used.
- `lsu2memCon_ifSigned` input 1: sign-extend the load result.
- `memCon2lsu_enable` output 1: LSU done pulse, for reads and writes.
- `memCon2lsu_return` output 32: load result; 0 for writes.
- `mem_din` input 8: RAM read data; valid the cycle after the address is presented.
- `mem_dout` output 8: RAM write data.
- `mem_a` output 32: RAM address.
- `mem_wr` output 1: 1 = write.
- `io_buffer_full` input 1: IO write buffer full.

## Operation
- FSM states: IDLE, READ, WRITE.
- Byte count n = 1, 2 or 4, taken from the width (the iCache always uses n = 4).
- Byte counter k counts 0..n+1.
- Accept happens in IDLE when `rdy_in` is high and a client enable is high.
- LSU has fixed priority over the iCache.
- On accept, the controller latches the address, rw, n, signedness, store data and the client ID. Clients hold their request fields stable until done.
- READ, byte-serial and little-endian:
  - On edge k after accept (k = 0..n-1), drive `mem_a` = addr + k and `mem_wr` = 0.
  - Capture byte k from `mem_din` at edge k+2.
  - The last byte is assembled combinationally with the buffered bytes and registered into the return output.
- Load result extension:
  - Width 0 signed: bits [31:8] = bit 7. Width 0 unsigned: bits [31:8] = 0.
  - Width 1 extends from bit 15 in the same way.
  - Width 2 is passed through unchanged.
- WRITE:
  - On edge k (k = 0..n-1), drive `mem_a` = addr + k, `mem_dout` = value[8k+7:8k], `mem_wr` = 1.
  - On edge n, drive `mem_wr` = 0 and assert done.
- Done handling:
  - Done asserts `memCon2lsu_enable` or `memCon2iCache_enable` (whichever client was served) for exactly one cycle, then the FSM returns to IDLE.
  - A new accept is possible on the next edge, so back-to-back requests incur no gap cycles.
- Address arithmetic wraps modulo 2^32.
- Clear:
  - `rob2memCon_clear` high during READ aborts the read: return to IDLE, drive `mem_wr` = 0, no done pulse.
  - A clear during WRITE is ignored; the store completes and pulses done.
  - A clear in IDLE blocks accept for that cycle.
- Reset values:
  - FSM = IDLE, k = 0.
  - `mem_a`, `mem_dout` and `mem_wr` = 0.
  - Both done outputs = 0.
  - Both return outputs = 0.
- In IDLE, `mem_wr` = 0 and `mem_a` holds its last value.
- Reset asserted mid-transfer drops the transfer immediately: no done pulse, and `mem_wr` = 0 on the next cycle.

## Timing
- The accept edge is E0.
- Reads: done is high in the cycle after edge E(n+1).
  - LB: 2 cycles.
  - LH: 3 cycles.
  - LW and fetch: 5 cycles.
- Writes: done is high in the cycle after edge E(n). SB: 1 cycle; SW: 4 cycles.
- Return data is valid in the same cycle as the done pulse and holds until the next done.
- Simultaneous iCache and LSU requests: LSU is accepted at E0. The iCache request is accepted on the first IDLE edge after the LSU done cycle, provided the LSU enable is low then.

## Configuration
- `MEMCON_IO_STALL_EN` defined: an LSU write whose address satisfies [17:16] == 2'b11 is not accepted while `io_buffer_full` is high.
  - The iCache may be granted in that case.
  - Once the write is accepted, it proceeds normally.
- Not defined: `io_buffer_full` is ignored.

## Test plan
- LW at 0x100, RAM bytes 0x11, 0x22, 0x33, 0x44 -> `mem_a` steps 0x100..0x103, then `memCon2lsu_return` = 0x44332211 with a one-cycle done, 5 cycles after accept.
- LB signed at byte 0x80, then LBU at the same byte, back-to-back -> returns 0xFFFFFF80 then 0x00000080, with no idle gap between the two transfers.
- SH of value 0xABCD1234 at 0x200 -> `mem_wr` = 1 with (0x200, 0x34) then (0x201, 0x12), done 2 cycles after accept, `mem_wr` = 0 afterwards.
- iCache fetch at 0x0 and LSU LW at 0x40 requested in the same cycle -> LSU is served first; the fetch is accepted after the LSU done; each client sees exactly one done pulse.
- `rob2memCon_clear` pulsed two cycles into a fetch -> no `memCon2iCache_enable`, FSM in IDLE; the same clear during an SW -> all 4 bytes are written and done pulses.
- With `MEMCON_IO_STALL_EN` defined, SB to 0x30000 while `io_buffer_full` = 1 for 3 cycles -> `mem_wr` stays 0 for those 3 cycles; the write is issued and done pulses once `io_buffer_full` falls.
